reset_source: RTL and testbench

- Generates reset requests for the chip-level reset stretcher. Its `res_req` output drives that stretcher's `async_res` input.
- Merges three reset sources into a single clean, fixed-width request pulse:
  - debounced external reset pin,
  - software reset strobe,
  - watchdog timeout.
- Latches a sticky cause register that software reads after restart.

---
 rtl/reset_source_pkg.sv | 15 +
 rtl/reset_debounce.sv | 48 ++++
 rtl/reset_source.sv | 138 +++++++++++++
 tb/tb_reset_source.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_source_pkg.sv
// Shared types and constants for the reset request generator.
package reset_source_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned CAUSE_PIN = 0;
  localparam int unsigned CAUSE_SW  = 1;
  localparam int unsigned CAUSE_WDT = 2;
  localparam int unsigned CAUSE_POR = 3;

endpackage

// File: rtl/reset_debounce.sv
// External reset pin: 2-flop synchronizer followed by a saturating low-sample counter.
// evt is a one-cycle registered pulse when the count saturates; low is the saturated level.
module reset_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic async_res,
  input  logic pin_resn,
  output logic evt,
  output logic low
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Pulse only on the cycle the count first reaches saturation.
    evt_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  always_ff @(posedge clock or posedge async_res) begin
    if (async_res) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= pin_resn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign evt = evt_q;
  assign low = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reset_source.sv
// Merges pin, software and watchdog reset sources into a fixed-width res_req pulse
// with a sticky cause register. Watchdog is built only when RESET_SOURCE_WDT_EN is defined.
module reset_source
  import reset_source_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned WDT_WIDTH       = 16
) (
  input  logic                 clock,
  input  logic                 async_res,
  input  logic                 pin_resn,
  input  logic                 sw_res,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic [WDT_WIDTH-1:0] wdt_load,
  input  logic                 cause_clr,
  output logic                 res_req,
  output logic [3:0]           cause,
  output logic                 busy
);

  localparam int unsigned PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PCW-1:0] PCNT_LOAD = PCW'(PULSE_CYCLES - 1);

  state_e         state_q, state_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           res_req_q, res_req_d;
  logic [3:0]     cause_q, cause_d;
  logic           pin_evt, pin_low, sw_evt, wdt_evt;

  reset_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .async_res(async_res),
    .pin_resn (pin_resn),
    .evt      (pin_evt),
    .low      (pin_low)
  );

  assign sw_evt = sw_res && (state_q == IDLE);

`ifdef RESET_SOURCE_WDT_EN
  logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
  logic                 wdt_en_q;

  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    wdt_evt   = 1'b0;
    // Load on enable rise or kick takes priority over the terminal count.
    if ((wdt_en && !wdt_en_q) || wdt_kick) begin
      wdt_cnt_d = wdt_load;
    end else if (wdt_en && (wdt_cnt_q != '0)) begin
      if (wdt_cnt_q == WDT_WIDTH'(1)) begin
        wdt_evt   = 1'b1;
        wdt_cnt_d = wdt_load;
      end else begin
        wdt_cnt_d = wdt_cnt_q - WDT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge async_res) begin
    if (async_res) begin
      wdt_cnt_q <= '0;
      wdt_en_q  <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_en_q  <= wdt_en;
    end
  end
`else
  logic wdt_unused;
  assign wdt_unused = ^{wdt_en, wdt_kick, wdt_load};
  assign wdt_evt    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE: begin
        if (pin_evt || sw_evt || wdt_evt) begin
          state_d = PULSE;
          pcnt_d  = PCNT_LOAD;
        end
      end
      PULSE: begin
        if (pcnt_q == '0) begin
          state_d = HOLD;
        end else begin
          pcnt_d = pcnt_q - PCW'(1);
        end
      end
      HOLD: begin
        if (!pin_low && !sw_res) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    res_req_d = (state_d == PULSE);
  end

  always_comb begin
    cause_d = cause_q;
    if (cause_clr) begin
      cause_d[2:0] = '0;
      if (state_q == IDLE) begin
        cause_d[CAUSE_POR] = 1'b0;
      end
    end
    // Events are applied after the clear so a coincident event wins.
    if (pin_evt) cause_d[CAUSE_PIN] = 1'b1;
    if (sw_evt)  cause_d[CAUSE_SW]  = 1'b1;
    if (wdt_evt) cause_d[CAUSE_WDT] = 1'b1;
  end

  always_ff @(posedge clock or posedge async_res) begin
    if (async_res) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      res_req_q <= 1'b0;
      cause_q   <= 4'b1000;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      res_req_q <= res_req_d;
      cause_q   <= cause_d;
    end
  end

  assign res_req = res_req_q;
  assign cause   = cause_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reset_source.sv
// Directed self-checking bench for reset_source (DEBOUNCE_CYCLES=16, PULSE_CYCLES=4).
// Watchdog scenarios are selected by RESET_SOURCE_WDT_EN to match the DUT build.
module tb_reset_source;

  logic        clock = 1'b0;
  logic        async_res;
  logic        pin_resn;
  logic        sw_res;
  logic        wdt_en;
  logic        wdt_kick;
  logic [15:0] wdt_load;
  logic        cause_clr;
  logic        res_req;
  logic [3:0]  cause;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  reset_source #(
    .DEBOUNCE_CYCLES(16),
    .PULSE_CYCLES   (4),
    .WDT_WIDTH      (16)
  ) dut (
    .clock    (clock),
    .async_res(async_res),
    .pin_resn (pin_resn),
    .sw_res   (sw_res),
    .wdt_en   (wdt_en),
    .wdt_kick (wdt_kick),
    .wdt_load (wdt_load),
    .cause_clr(cause_clr),
    .res_req  (res_req),
    .cause    (cause),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_cause();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
  endtask

  task automatic test_reset();
    async_res = 1'b1;
    pin_resn  = 1'b1;
    sw_res    = 1'b0;
    wdt_en    = 1'b0;
    wdt_kick  = 1'b0;
    wdt_load  = '0;
    cause_clr = 1'b0;
    tick();
    tick();
    async_res = 1'b0;
    tick();
    n_checks++;
    if (res_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_res_req got %b exp 0", res_req);
    end
    n_checks++;
    if (cause !== 4'b1000) begin
      n_fail++; $display("FAIL reset_cause got %b exp 1000", cause);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b exp 0", busy);
    end
    clear_cause();
    n_checks++;
    if (cause !== 4'b0000) begin
      n_fail++; $display("FAIL reset_clear_por got %b exp 0000", cause);
    end
  endtask

  task automatic test_pin_glitch();
    pin_resn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
    end
    pin_resn = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      n_checks++;
      if (res_req !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL pin_glitch k=%0d res_req=%b busy=%b exp 0/0", k, res_req, busy);
      end
    end
    n_checks++;
    if (cause !== 4'b0000) begin
      n_fail++; $display("FAIL pin_glitch_cause got %b exp 0000", cause);
    end
  endtask

  task automatic test_pin_hold();
    logic exp_req;
    pin_resn = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_req = (k >= 19 && k <= 22);
      n_checks++;
      if (res_req !== exp_req) begin
        n_fail++; $display("FAIL pin_hold_req k=%0d got %b exp %b", k, res_req, exp_req);
      end
      n_checks++;
      if (busy !== (k >= 19)) begin
        n_fail++; $display("FAIL pin_hold_busy k=%0d got %b exp %b", k, busy, (k >= 19));
      end
    end
    n_checks++;
    if (cause !== 4'b0001) begin
      n_fail++; $display("FAIL pin_hold_cause got %b exp 0001", cause);
    end
    pin_resn = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      n_checks++;
      if (busy !== (j < 4)) begin
        n_fail++; $display("FAIL pin_release_busy j=%0d got %b exp %b", j, busy, (j < 4));
      end
    end
  endtask

  task automatic test_sw();
    logic exp_req;
    clear_cause();
    for (int k = 1; k <= 8; k++) begin
      sw_res = (k == 1 || k == 3);
      tick();
      sw_res = 1'b0;
      exp_req = (k <= 4);
      n_checks++;
      if (res_req !== exp_req) begin
        n_fail++; $display("FAIL sw_req k=%0d got %b exp %b", k, res_req, exp_req);
      end
      n_checks++;
      if (busy !== (k <= 5)) begin
        n_fail++; $display("FAIL sw_busy k=%0d got %b exp %b", k, busy, (k <= 5));
      end
    end
    n_checks++;
    if (cause !== 4'b0010) begin
      n_fail++; $display("FAIL sw_cause got %b exp 0010", cause);
    end
  endtask

`ifdef RESET_SOURCE_WDT_EN
  task automatic test_wdt();
    logic exp_req;
    clear_cause();
    wdt_load = 16'd5;
    wdt_en   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_req = (k >= 6 && k <= 9);
      n_checks++;
      if (res_req !== exp_req) begin
        n_fail++; $display("FAIL wdt_req k=%0d got %b exp %b", k, res_req, exp_req);
      end
    end
    n_checks++;
    if (cause !== 4'b0100) begin
      n_fail++; $display("FAIL wdt_cause got %b exp 0100", cause);
    end
    wdt_en = 1'b0;
    tick();
    tick();
    tick();
    wdt_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      wdt_kick = (k % 3 == 0);
      tick();
      wdt_kick = 1'b0;
      n_checks++;
      if (res_req !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL wdt_kick k=%0d res_req=%b busy=%b exp 0/0", k, res_req, busy);
      end
    end
    wdt_en   = 1'b0;
    tick();
    wdt_load = 16'd0;
    wdt_en   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if (res_req !== 1'b0) begin
        n_fail++; $display("FAIL wdt_zero k=%0d got %b exp 0", k, res_req);
      end
    end
    wdt_en = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    logic exp_req;
    clear_cause();
    wdt_load = 16'd3;
    wdt_en   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      sw_res    = (k == 4);
      cause_clr = (k == 4);
      tick();
      sw_res    = 1'b0;
      cause_clr = 1'b0;
      if (k == 4) begin
        wdt_en = 1'b0;
        n_checks++;
        if (cause !== 4'b0110) begin
          n_fail++; $display("FAIL simul_cause got %b exp 0110", cause);
        end
      end
      exp_req = (k >= 4 && k <= 7);
      n_checks++;
      if (res_req !== exp_req) begin
        n_fail++; $display("FAIL simul_req k=%0d got %b exp %b", k, res_req, exp_req);
      end
    end
  endtask
`else
  task automatic test_wdt_disabled();
    clear_cause();
    wdt_load = 16'd5;
    wdt_en   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      wdt_kick = (k == 10);
      tick();
      wdt_kick = 1'b0;
      n_checks++;
      if (res_req !== 1'b0) begin
        n_fail++; $display("FAIL wdt_off_req k=%0d got %b exp 0", k, res_req);
      end
    end
    wdt_en = 1'b0;
    n_checks++;
    if (cause !== 4'b0000) begin
      n_fail++; $display("FAIL wdt_off_cause got %b exp 0000", cause);
    end
  endtask
`endif

  task automatic test_mid_pulse_reset();
    clear_cause();
    sw_res = 1'b1;
    tick();
    sw_res = 1'b0;
    tick();
    n_checks++;
    if (res_req !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre got %b exp 1", res_req);
    end
    #2;
    async_res = 1'b1;
    #1;
    n_checks++;
    if (res_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async res_req=%b busy=%b exp 0/0", res_req, busy);
    end
    tick();
    async_res = 1'b0;
    tick();
    n_checks++;
    if (cause !== 4'b1000) begin
      n_fail++; $display("FAIL midrst_cause got %b exp 1000", cause);
    end
    n_checks++;
    if (res_req !== 1'b0) begin
      n_fail++; $display("FAIL midrst_req got %b exp 0", res_req);
    end
  endtask

  initial begin
    test_reset();
    test_pin_glitch();
    test_pin_hold();
    test_sw();
`ifdef RESET_SOURCE_WDT_EN
    test_wdt();
    test_simultaneous();
`else
    test_wdt_disabled();
`endif
    test_mid_pulse_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
